// File: rtl/i2c_slave_responder.sv
// I2C target responder: filtered SCL/SDA, START/STOP detection, address match,
// write-byte receive and read-byte transmit. SDA is open-drain via sda_oe.
module i2c_slave_responder #(
    parameter logic [6:0] ADDRESS    = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addressed,
    output logic       read_mode,
    output logic       busy
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    filt;
    logic [1:0]    dly;
    logic [CW-1:0] fcnt [2];

    assign raw = {scl_in, sda_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 2'b11;
            s2      <= 2'b11;
            filt    <= 2'b11;
            dly     <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            dly <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_rise  = filt[1] & ~dly[1];
    assign scl_fall  = ~filt[1] & dly[1];
    assign start_det = filt[1] & dly[1] & dly[0] & ~filt[0];
    assign stop_det  = scl_f & dly[1] & ~dly[0] & sda_f;

    state_t     state;
    state_t     state_n;
    logic [3:0] bcnt;
    logic [3:0] bcnt_n;
    logic [7:0] sh;
    logic [7:0] sh_n;
    logic       phase;
    logic       phase_n;
    logic       oe_n;
    logic       addr_n;
    logic       rm_n;
    logic       busy_n;
    logic [7:0] rxd_n;
    logic       rxv_n;
    logic       txl_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bcnt      <= '0;
            sh        <= '0;
            phase     <= 1'b0;
            sda_oe    <= 1'b0;
            addressed <= 1'b0;
            read_mode <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
        end else begin
            state     <= state_n;
            bcnt      <= bcnt_n;
            sh        <= sh_n;
            phase     <= phase_n;
            sda_oe    <= oe_n;
            addressed <= addr_n;
            read_mode <= rm_n;
            busy      <= busy_n;
            rx_data   <= rxd_n;
            rx_valid  <= rxv_n;
            tx_load   <= txl_n;
        end
    end

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        sh_n    = sh;
        phase_n = phase;
        oe_n    = sda_oe;
        addr_n  = addressed;
        rm_n    = read_mode;
        busy_n  = busy;
        rxd_n   = rx_data;
        rxv_n   = 1'b0;
        txl_n   = 1'b0;
        if (stop_det) begin
            state_n = IDLE;
            bcnt_n  = '0;
            phase_n = 1'b0;
            oe_n    = 1'b0;
            addr_n  = 1'b0;
            busy_n  = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            bcnt_n  = '0;
            sh_n    = '0;
            phase_n = 1'b0;
            oe_n    = 1'b0;
            addr_n  = 1'b0;
            busy_n  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    oe_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        sh_n   = {sh[6:0], sda_f};
                        bcnt_n = bcnt + 4'd1;
                        if (bcnt == 4'd7) begin
                            // sh[6:0] becomes the received address bits [7:1]
                            bcnt_n  = '0;
                            phase_n = 1'b0;
                            state_n = (sh[6:0] == ADDRESS) ? ADDR_ACK
                                                           : WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_n    = 1'b1;
                            addr_n  = 1'b1;
                            rm_n    = sh[0];
                            phase_n = 1'b1;
                        end else begin
                            phase_n = 1'b0;
                            bcnt_n  = '0;
                            if (read_mode) begin
                                txl_n   = 1'b1;
                                sh_n    = tx_data;
                                oe_n    = ~tx_data[7];
                                state_n = RD_BYTE;
                            end else begin
                                oe_n    = 1'b0;
                                state_n = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (bcnt == 4'd8) begin
                        rxd_n   = sh;
                        rxv_n   = 1'b1;
                        bcnt_n  = '0;
                        phase_n = 1'b0;
                        state_n = WR_ACK;
                    end else if (scl_rise) begin
                        sh_n   = {sh[6:0], sda_f};
                        bcnt_n = bcnt + 4'd1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_n    = 1'b1;
                            phase_n = 1'b1;
                        end else begin
                            oe_n    = 1'b0;
                            phase_n = 1'b0;
                            bcnt_n  = '0;
                            state_n = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bcnt == 4'd7) begin
                            oe_n    = 1'b0;
                            bcnt_n  = '0;
                            phase_n = 1'b0;
                            state_n = RD_ACK;
                        end else begin
                            oe_n   = ~sh[6];
                            sh_n   = {sh[6:0], 1'b0};
                            bcnt_n = bcnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (!phase) begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                phase_n = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        txl_n   = 1'b1;
                        sh_n    = tx_data;
                        oe_n    = ~tx_data[7];
                        bcnt_n  = '0;
                        phase_n = 1'b0;
                        state_n = RD_BYTE;
                    end
                end
                WAIT_STOP: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-level I2C master on a wired-AND bus,
// directed scenarios plus random transactions checked against queue models.
module tb_i2c_slave_responder;

    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load;
    logic       addressed;
    logic       read_mode;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int txl_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_responder #(
        .ADDRESS   (7'h50),
        .FILTER_LEN(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .addressed(addressed),
        .read_mode(read_mode),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (tx_load) txl_cnt = txl_cnt + 1;
        if (sda_oe) oe_cnt = oe_cnt + 1;
        tx_data = (txl_cnt < txq.size()) ? txq[txl_cnt] : 8'h00;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within cycle budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        waitc(Q);
        scl_m = 1'b1;
        waitc(Q);
        sda_m = 1'b0;
        waitc(Q);
        scl_m = 1'b0;
        waitc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        waitc(Q);
        scl_m = 1'b1;
        waitc(Q);
        sda_m = 1'b1;
        waitc(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        waitc(Q);
        scl_m = 1'b1;
        waitc(2 * Q);
        scl_m = 1'b0;
        waitc(Q);
    endtask

    // Same bit, but with a 1-clk SCL spike while low and an SDA spike
    // while high that would read as START/STOP if it got through.
    task automatic write_bit_g(input logic b);
        sda_m = b;
        waitc(Q / 2);
        scl_m = 1'b1;
        @(posedge clk);
        scl_m = 1'b0;
        waitc(Q / 2);
        scl_m = 1'b1;
        waitc(Q);
        sda_m = ~b;
        @(posedge clk);
        sda_m = b;
        waitc(Q);
        scl_m = 1'b0;
        waitc(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        waitc(Q);
        scl_m = 1'b1;
        waitc(Q);
        @(negedge clk);
        b = sda_bus;
        waitc(Q);
        scl_m = 1'b0;
        waitc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic write_byte_g(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit_g(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] gd;
        logic [6:0] a7;
        logic       rw;
        logic       match;
        int         n;
        int         base_rx;
        int         base_tx;
        int         base_oe;
        logic [7:0] exp_q[$];

        // reset state
        waitc(4);
        @(negedge clk);
        chk("reset_outputs", 32'({sda_oe, rx_valid, tx_load, addressed,
                                  read_mode, busy}), 32'(0));
        chk("reset_rx_data", 32'(rx_data), 32'(0));
        reset = 1'b0;
        waitc(10);

        // write 0x50: two data bytes
        base_rx = rxq.size();
        i2c_start();
        chk("t1_busy_after_start", 32'(busy), 32'(1));
        write_byte(8'hA0, ack);
        chk("t1_addr_ack", 32'(ack), 32'(0));
        chk("t1_addressed", 32'(addressed), 32'(1));
        chk("t1_read_mode", 32'(read_mode), 32'(0));
        write_byte(8'h3C, ack);
        chk("t1_ack_b1", 32'(ack), 32'(0));
        write_byte(8'hC3, ack);
        chk("t1_ack_b2", 32'(ack), 32'(0));
        i2c_stop();
        chk("t1_busy_after_stop", 32'(busy), 32'(0));
        chk("t1_addressed_stop", 32'(addressed), 32'(0));
        chk("t1_rx_count", 32'(rxq.size() - base_rx), 32'(2));
        if (rxq.size() - base_rx == 2) begin
            chk("t1_rx0", 32'(rxq[base_rx]), 32'(8'h3C));
            chk("t1_rx1", 32'(rxq[base_rx + 1]), 32'(8'hC3));
        end

        // foreign address 0x51
        base_rx = rxq.size();
        base_oe = oe_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        chk("t2_addr_nack", 32'(ack), 32'(1));
        write_byte(8'h77, ack);
        chk("t2_data_nack", 32'(ack), 32'(1));
        chk("t2_addressed", 32'(addressed), 32'(0));
        i2c_stop();
        chk("t2_no_oe", 32'(oe_cnt - base_oe), 32'(0));
        chk("t2_no_rx", 32'(rxq.size() - base_rx), 32'(0));

        // read 0x50: two bytes, ACK then NACK
        base_tx = txl_cnt;
        txq.push_back(8'h96);
        txq.push_back(8'h5A);
        waitc(2);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("t3_addr_ack", 32'(ack), 32'(0));
        chk("t3_read_mode", 32'(read_mode), 32'(1));
        read_byte(1'b0, d);
        chk("t3_rd0", 32'(d), 32'(8'h96));
        read_byte(1'b1, d);
        chk("t3_rd1", 32'(d), 32'(8'h5A));
        waitc(4);
        @(negedge clk);
        chk("t3_oe_after_nack", 32'(sda_oe), 32'(0));
        i2c_stop();
        chk("t3_tx_loads", 32'(txl_cnt - base_tx), 32'(2));

        // write, repeated START, read one byte
        base_rx = rxq.size();
        base_tx = txl_cnt;
        gd = 8'($urandom);
        txq.push_back(gd);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("t4_addr_w_ack", 32'(ack), 32'(0));
        chk("t4_read_mode_w", 32'(read_mode), 32'(0));
        write_byte(8'h11, ack);
        chk("t4_ack_data", 32'(ack), 32'(0));
        i2c_start();
        chk("t4_addressed_restart", 32'(addressed), 32'(0));
        chk("t4_busy_restart", 32'(busy), 32'(1));
        write_byte(8'hA1, ack);
        chk("t4_addr_r_ack", 32'(ack), 32'(0));
        chk("t4_addressed_again", 32'(addressed), 32'(1));
        chk("t4_read_mode_r", 32'(read_mode), 32'(1));
        read_byte(1'b1, d);
        chk("t4_rd", 32'(d), 32'(gd));
        i2c_stop();
        chk("t4_rx_count", 32'(rxq.size() - base_rx), 32'(1));
        chk("t4_rx_data", 32'(rx_data), 32'(8'h11));
        chk("t4_tx_loads", 32'(txl_cnt - base_tx), 32'(1));

        // reset while driving a 0 bit of a read byte
        base_tx = txl_cnt;
        gd = {1'b0, 7'($urandom)};
        txq.push_back(gd);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("t5_addr_ack", 32'(ack), 32'(0));
        @(negedge clk);
        chk("t5_driving_zero", 32'(sda_oe), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("t5_oe_released", 32'(sda_oe), 32'(0));
        chk("t5_reset_outputs", 32'({sda_oe, rx_valid, tx_load, addressed,
                                     read_mode, busy}), 32'(0));
        chk("t5_reset_rx_data", 32'(rx_data), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        chk("t5_tx_loads", 32'(txl_cnt - base_tx), 32'(1));
        waitc(Q);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("t5_after_reset_ack", 32'(ack), 32'(0));
        chk("t5_after_reset_addr", 32'(addressed), 32'(1));
        i2c_stop();

        // 1-clk spikes at idle and inside a write byte
        base_rx = rxq.size();
        base_oe = oe_cnt;
        waitc(Q);
        sda_m = 1'b0;
        @(posedge clk);
        sda_m = 1'b1;
        waitc(Q);
        scl_m = 1'b0;
        @(posedge clk);
        scl_m = 1'b1;
        waitc(Q);
        chk("t6_idle_busy", 32'(busy), 32'(0));
        chk("t6_idle_oe", 32'(oe_cnt - base_oe), 32'(0));
        chk("t6_idle_addressed", 32'(addressed), 32'(0));
        gd = 8'($urandom);
        i2c_start();
        write_byte(8'hA0, ack);
        chk("t6_addr_ack", 32'(ack), 32'(0));
        write_byte_g(gd, ack);
        chk("t6_glitch_ack", 32'(ack), 32'(0));
        chk("t6_glitch_busy", 32'(busy), 32'(1));
        chk("t6_glitch_addressed", 32'(addressed), 32'(1));
        i2c_stop();
        chk("t6_rx_count", 32'(rxq.size() - base_rx), 32'(1));
        if (rxq.size() - base_rx == 1)
            chk("t6_rx_data", 32'(rxq[base_rx]), 32'(gd));

        // random transactions against the queue model
        for (int t = 0; t < 6; t++) begin
            a7 = ($urandom_range(0, 1) == 1) ? 7'h50
                                             : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            match = (a7 == 7'h50);
            base_rx = rxq.size();
            base_tx = txl_cnt;
            base_oe = oe_cnt;
            exp_q.delete();
            if (match && rw) begin
                for (int i = 0; i < n; i++) begin
                    d = 8'($urandom);
                    txq.push_back(d);
                    exp_q.push_back(d);
                end
            end
            waitc(2);
            i2c_start();
            write_byte({a7, rw}, ack);
            chk("rnd_addr_ack", 32'(ack), 32'(match ? 0 : 1));
            if (!match) begin
                write_byte(8'($urandom), ack);
                chk("rnd_foreign_nack", 32'(ack), 32'(1));
                i2c_stop();
                chk("rnd_foreign_oe", 32'(oe_cnt - base_oe), 32'(0));
                chk("rnd_foreign_rx", 32'(rxq.size() - base_rx), 32'(0));
            end else if (!rw) begin
                for (int i = 0; i < n; i++) begin
                    d = 8'($urandom);
                    exp_q.push_back(d);
                    write_byte(d, ack);
                    chk("rnd_wr_ack", 32'(ack), 32'(0));
                end
                i2c_stop();
                chk("rnd_wr_count", 32'(rxq.size() - base_rx), 32'(n));
                if (rxq.size() - base_rx == n)
                    for (int i = 0; i < n; i++)
                        chk("rnd_wr_data", 32'(rxq[base_rx + i]),
                            32'(exp_q[i]));
            end else begin
                for (int i = 0; i < n; i++) begin
                    read_byte(i == n - 1, d);
                    chk("rnd_rd_data", 32'(d), 32'(exp_q[i]));
                end
                i2c_stop();
                chk("rnd_rd_loads", 32'(txl_cnt - base_tx), 32'(n));
            end
            chk("rnd_busy_idle", 32'(busy), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
